render_scheduler: RTL and testbench
===================================

RENDER_SCHEDULER -- requirements
Module: render_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 320, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 180, frame height in pixels.
REQ-003 SHALL have parameter NUM_CORES, default 2, number of render cores served.
REQ-004 SHALL have port clk_pixel_in, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start_in, input, 1, single-cycle request to render one frame.
REQ-007 SHALL have port busy_out, input-independent output, 1, high from frame start until frame_done_out.
REQ-008 SHALL have port frame_done_out, output, 1, one-cycle pulse when the frame is fully written.
REQ-009 SHALL have ports job_valid_out output [NUM_CORES] and job_ready_in input [NUM_CORES], per-core job handshake.
REQ-010 SHALL have ports job_x_out output 9 and job_y_out output 8, the shared job coordinate bus.
REQ-011 SHALL have ports res_valid_in input [NUM_CORES] and res_ready_out output [NUM_CORES], per-core result handshake.
REQ-012 SHALL have ports res_x_in input [NUM_CORES][9], res_y_in input [NUM_CORES][8], res_rgb_in input [NUM_CORES][24], per-core result payload.
REQ-013 SHALL have ports fb_we_out output 1, fb_addr_out output 16, fb_data_out output 24, framebuffer write port.

Function
REQ-014 SHALL implement states IDLE, DISPATCH, DRAIN, DONE; IDLE->DISPATCH on start_in; DISPATCH->DRAIN after job (WIDTH-1,HEIGHT-1) transfers; DRAIN->DONE when outstanding==0 and no fb write pending; DONE->IDLE after one cycle.
REQ-015 SHALL issue coordinates in raster order: x increments 0..WIDTH-1, wraps to 0 with y+1; y 0..HEIGHT-1.
REQ-016 SHALL assert at most one job_valid_out bit per cycle, only in DISPATCH, selecting among cores with job_ready_in high by round-robin starting after the last-granted core.
REQ-017 SHALL treat a job as transferred when job_valid_out[i] && job_ready_in[i] in the same cycle; coordinates advance only on transfer.
REQ-018 SHALL deassert all job_valid_out when no core is ready; coordinate held.
REQ-019 SHALL assert at most one res_ready_out bit per cycle, round-robin among res_valid_in, independent pointer from job arbiter, active in DISPATCH and DRAIN.
REQ-020 SHALL register an accepted result to fb_we_out=1, fb_addr_out=y*WIDTH+x, fb_data_out=rgb exactly one cycle after acceptance.
REQ-021 SHALL keep a 16-bit outstanding counter: +1 on job transfer, -1 on result acceptance, unchanged when both occur in the same cycle.
REQ-022 SHALL ignore start_in while busy_out is high.
REQ-023 SHALL hold fb_we_out low except for REQ-020 writes; fb_addr_out/fb_data_out hold last value otherwise.
REQ-024 SHALL assert busy_out in DISPATCH, DRAIN and DONE; frame_done_out high only in DONE.

Reset
REQ-025 SHALL on rst_in low, immediately and regardless of state, force state IDLE, x=y=0, outstanding=0, both round-robin pointers to core 0, all outputs 0.
REQ-026 SHALL discard in-flight jobs on reset mid-frame; no frame_done_out pulse for the aborted frame.

Structure
REQ-027 SHALL place the state enum, coordinate widths (9/8), address width 16 and RGB width 24 in shared package render_pkg.
REQ-028 SHALL implement both arbiters as two instances of sub-module rr_arbiter (NUM_CORES request in, one-hot grant out, pointer advances on grant).

Verification
REQ-029 Reset then start_in pulse, WIDTH=4 HEIGHT=2, one core always ready with 3-cycle result latency -> 8 fb writes, addresses 0..7 in order, one frame_done_out pulse.
REQ-030 Two cores, both ready every cycle -> job grants alternate core0/core1; no cycle with two job_valid_out bits.
REQ-031 Both res_valid_in high simultaneously for 4 cycles -> res_ready_out alternates, each result written once, outstanding decrements by 1 per cycle.
REQ-032 job_ready_in low for 10 cycles mid-frame at (2,1) -> job_x_out=2, job_y_out=1 held, no coordinate skipped.
REQ-033 Result x=319 y=179 at default size -> fb_addr_out=57599 one cycle after acceptance.
REQ-034 rst_in low during DRAIN with outstanding=3 -> all outputs 0 same cycle, state IDLE, no frame_done_out; next start_in renders full frame.

Source files
------------

// File: rtl/render_pkg.sv
// Shared types and widths for the render scheduler.
// Coordinate, address and colour widths live here so all units agree.
package render_pkg;

    localparam int X_W    = 9;
    localparam int Y_W    = 8;
    localparam int ADDR_W = 16;
    localparam int RGB_W  = 24;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with one-hot grant.
// The pointer names the highest-priority core and moves past each winner.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          found;
    int            pos;

    // Grant the first requester found scanning upward from the pointer.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (en && !found && req[PW'(pos)]) begin
                found             = 1'b1;
                grant[PW'(pos)]   = 1'b1;
                ptr_nxt = (pos == N - 1) ? '0 : PW'(pos + 1);
            end
        end
    end

    // Advance priority only when a grant is actually issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/render_scheduler.sv
// Frame render scheduler: hands raster jobs to cores and
// collects their pixels into framebuffer writes.
module render_scheduler
    import render_pkg::*;
#(
    parameter int WIDTH     = 320,
    parameter int HEIGHT    = 180,
    parameter int NUM_CORES = 2
) (
    input  logic                                clk_pixel_in,
    input  logic                                rst_in,
    input  logic                                start_in,
    output logic                                busy_out,
    output logic                                frame_done_out,
    output logic [NUM_CORES-1:0]                job_valid_out,
    input  logic [NUM_CORES-1:0]                job_ready_in,
    output logic [X_W-1:0]                      job_x_out,
    output logic [Y_W-1:0]                      job_y_out,
    input  logic [NUM_CORES-1:0]                res_valid_in,
    output logic [NUM_CORES-1:0]                res_ready_out,
    input  logic [NUM_CORES-1:0][X_W-1:0]       res_x_in,
    input  logic [NUM_CORES-1:0][Y_W-1:0]       res_y_in,
    input  logic [NUM_CORES-1:0][RGB_W-1:0]     res_rgb_in,
    output logic                                fb_we_out,
    output logic [ADDR_W-1:0]                   fb_addr_out,
    output logic [RGB_W-1:0]                    fb_data_out
);

    state_t               state;
    state_t               state_nxt;
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic [CNT_W-1:0]     outstanding;
    logic [NUM_CORES-1:0] job_gnt;
    logic [NUM_CORES-1:0] res_gnt;
    logic                 job_en;
    logic                 res_en;
    logic                 job_xfer;
    logic                 res_acc;
    logic                 x_last;
    logic                 y_last;
    logic                 last_job;
    logic [X_W-1:0]       sel_x;
    logic [Y_W-1:0]       sel_y;
    logic [RGB_W-1:0]     sel_rgb;

    assign job_en   = (state == DISPATCH);
    assign res_en   = (state == DISPATCH) || (state == DRAIN);
    assign job_xfer = |job_gnt;
    assign res_acc  = |res_gnt;
    assign x_last   = (x == X_W'(WIDTH - 1));
    assign y_last   = (y == Y_W'(HEIGHT - 1));
    assign last_job = job_xfer && x_last && y_last;

    assign job_valid_out = job_gnt;
    assign res_ready_out = res_gnt;
    assign job_x_out     = x;
    assign job_y_out     = y;

    rr_arbiter #(.N(NUM_CORES)) u_job_arb (
        .clk   (clk_pixel_in),
        .rst_n (rst_in),
        .en    (job_en),
        .req   (job_ready_in),
        .grant (job_gnt)
    );

    rr_arbiter #(.N(NUM_CORES)) u_res_arb (
        .clk   (clk_pixel_in),
        .rst_n (rst_in),
        .en    (res_en),
        .req   (res_valid_in),
        .grant (res_gnt)
    );

    // State register.
    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status outputs; drain waits for the last write.
    always_comb begin
        state_nxt      = state;
        busy_out       = 1'b1;
        frame_done_out = 1'b0;
        case (state)
            IDLE: begin
                busy_out = 1'b0;
                if (start_in) begin
                    state_nxt = DISPATCH;
                end
            end
            DISPATCH: begin
                if (last_job) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding == '0 && !fb_we_out) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done_out = 1'b1;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Raster coordinate walk, advancing only on a job transfer.
    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            x <= '0;
            y <= '0;
        end else if (state == IDLE && start_in) begin
            x <= '0;
            y <= '0;
        end else if (job_xfer) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // Jobs handed out but not yet returned.
    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            outstanding <= '0;
        end else begin
            case ({job_xfer, res_acc})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Steer the granted core's result payload.
    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_rgb = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (res_gnt[i]) begin
                sel_x   = res_x_in[i];
                sel_y   = res_y_in[i];
                sel_rgb = res_rgb_in[i];
            end
        end
    end

    // Framebuffer write one cycle after acceptance; address and data hold.
    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            fb_we_out   <= 1'b0;
            fb_addr_out <= '0;
            fb_data_out <= '0;
        end else begin
            fb_we_out <= res_acc;
            if (res_acc) begin
                fb_addr_out <= ADDR_W'(sel_y) * ADDR_W'(WIDTH)
                             + ADDR_W'(sel_x);
                fb_data_out <= sel_rgb;
            end
        end
    end

endmodule

// File: tb/tb_render_scheduler.sv
// Bench for render_scheduler: a small frame driven by modelled cores,
// plus a default-size instance for address arithmetic.
module tb_render_scheduler;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int N    = 2;
    localparam int NPIX = W * H;

    localparam int M_ONE   = 0;
    localparam int M_BOTH  = 1;
    localparam int M_HOLD  = 2;
    localparam int M_STALL = 3;
    localparam int M_RAND  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic                a_start, a_busy, a_done, a_we;
    logic [N-1:0]        a_jv, a_jr, a_rv, a_rr;
    logic [8:0]          a_jx;
    logic [7:0]          a_jy;
    logic [N-1:0][8:0]   a_rx;
    logic [N-1:0][7:0]   a_ry;
    logic [N-1:0][23:0]  a_rgb;
    logic [15:0]         a_addr;
    logic [23:0]         a_data;

    logic                b_start, b_busy, b_done, b_we;
    logic [N-1:0]        b_jv, b_jr, b_rv, b_rr;
    logic [8:0]          b_jx;
    logic [7:0]          b_jy;
    logic [N-1:0][8:0]   b_rx;
    logic [N-1:0][7:0]   b_ry;
    logic [N-1:0][23:0]  b_rgb;
    logic [15:0]         b_addr;
    logic [23:0]         b_data;

    render_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_CORES(N)) dut_a (
        .clk_pixel_in(clk), .rst_in(rst_n), .start_in(a_start),
        .busy_out(a_busy), .frame_done_out(a_done),
        .job_valid_out(a_jv), .job_ready_in(a_jr),
        .job_x_out(a_jx), .job_y_out(a_jy),
        .res_valid_in(a_rv), .res_ready_out(a_rr),
        .res_x_in(a_rx), .res_y_in(a_ry), .res_rgb_in(a_rgb),
        .fb_we_out(a_we), .fb_addr_out(a_addr), .fb_data_out(a_data)
    );

    render_scheduler dut_b (
        .clk_pixel_in(clk), .rst_in(rst_n), .start_in(b_start),
        .busy_out(b_busy), .frame_done_out(b_done),
        .job_valid_out(b_jv), .job_ready_in(b_jr),
        .job_x_out(b_jx), .job_y_out(b_jy),
        .res_valid_in(b_rv), .res_ready_out(b_rr),
        .res_x_in(b_rx), .res_y_in(b_ry), .res_rgb_in(b_rgb),
        .fb_we_out(b_we), .fb_addr_out(b_addr), .fb_data_out(b_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] rgb_of(input int x, input int y);
        return 24'(x * 40503 + y * 7919 + 12345);
    endfunction

    // Spec rule: first requester in cyclic order after the last winner.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req,
                                             input int last);
        logic [N-1:0] g;
        int c;
        g = '0;
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (req[c] && g == '0) g[c] = 1'b1;
        end
        return g;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        int r;
        r = 0;
        for (int k = 0; k < N; k++) if (v[k]) r = k;
        return r;
    endfunction

    typedef struct {
        int core;
        int x;
        int y;
        int due;
    } job_t;

    job_t pend[$];
    int   t, issued, writes, accepts, last_wr_t, jlast, rlast;
    int   stall_cnt, mode, exp_addr;
    bit   started, done_seen, exp_wr;
    logic [23:0] exp_data;
    bit   written[NPIX];

    task automatic step(input bit st);
        logic [N-1:0] rdy, vld, eg, er;
        int hi[N];
        bit hold, disp, busy_m, exp_done;
        int c, p, lat;
        @(negedge clk);
        busy_m = started && !done_seen;
        a_start = st || (mode == M_RAND && busy_m
                         && $urandom_range(0, 7) == 0);
        hold = (mode == M_HOLD) && (issued < NPIX);
        case (mode)
            M_ONE:   rdy = 2'b01;
            M_STALL: begin
                if (issued == 6 && stall_cnt < 10) begin
                    rdy = '0;
                    stall_cnt++;
                end else begin
                    rdy = '1;
                end
            end
            M_RAND:  rdy = N'($urandom_range(0, (1 << N) - 1));
            default: rdy = '1;
        endcase
        a_jr = rdy;
        vld = '0;
        for (int i = 0; i < N; i++) begin
            hi[i] = -1;
            for (int q = 0; q < pend.size(); q++)
                if (hi[i] < 0 && pend[q].core == i) hi[i] = q;
            if (hi[i] >= 0 && !hold && pend[hi[i]].due <= t) begin
                vld[i]   = 1'b1;
                a_rx[i]  = 9'(pend[hi[i]].x);
                a_ry[i]  = 8'(pend[hi[i]].y);
                a_rgb[i] = rgb_of(pend[hi[i]].x, pend[hi[i]].y);
            end else begin
                a_rx[i]  = 9'($urandom);
                a_ry[i]  = 8'($urandom);
                a_rgb[i] = 24'($urandom);
            end
        end
        a_rv = vld;
        #1;
        disp = started && issued < NPIX;
        chk("busy", a_busy, busy_m);
        chk("job_onehot", $countones(a_jv) <= 1, 1);
        eg = disp ? rr_pick(rdy, jlast) : '0;
        chk("job_grant", a_jv, eg);
        if (disp) begin
            chk("job_x", a_jx, issued % W);
            chk("job_y", a_jy, issued / W);
        end
        er = rr_pick(vld, rlast);
        chk("res_grant", a_rr, er);
        chk("fb_we", a_we, exp_wr);
        chk("fb_addr", a_addr, exp_addr);
        chk("fb_data", a_data, exp_data);
        if (exp_wr) begin
            chk("fb_once", written[exp_addr], 0);
            if (mode == M_ONE) chk("fb_order", exp_addr, writes);
            written[exp_addr] = 1'b1;
            writes++;
            last_wr_t = t;
        end
        exp_done = busy_m && writes == NPIX && t == last_wr_t + 2;
        chk("frame_done", a_done, exp_done);
        if (a_start && !busy_m) started = 1'b1;
        if (eg != '0) begin
            c = idx_of(eg);
            lat = (mode == M_ONE) ? 3 :
                  (mode == M_RAND) ? $urandom_range(1, 4) : 1;
            pend.push_back('{c, issued % W, issued / W, t + lat});
            issued++;
            jlast = c;
        end
        if (er != '0) begin
            c = idx_of(er);
            p = hi[c];
            exp_addr = pend[p].y * W + pend[p].x;
            exp_data = rgb_of(pend[p].x, pend[p].y);
            pend.delete(p);
            exp_wr = 1'b1;
            accepts++;
            rlast = c;
        end else begin
            exp_wr = 1'b0;
        end
        if (a_done) done_seen = 1'b1;
        @(posedge clk);
        t++;
    endtask

    task automatic run_frame(input int m, input int abort_at);
        int n;
        mode = m;
        issued = 0;
        writes = 0;
        accepts = 0;
        started = 1'b0;
        done_seen = 1'b0;
        stall_cnt = 0;
        last_wr_t = -100;
        for (int i = 0; i < NPIX; i++) written[i] = 1'b0;
        step(1'b1);
        n = 0;
        while (!done_seen && n < 400 &&
               !(abort_at >= 0 && accepts >= abort_at)) begin
            step(1'b0);
            n++;
        end
        if (abort_at < 0) begin
            chk("frame_finished", done_seen, 1);
            chk("frame_writes", writes, NPIX);
        end
    endtask

    task automatic check_a_zero(input string tag);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_done"}, a_done, 0);
        chk({tag, "_jv"}, a_jv, 0);
        chk({tag, "_rr"}, a_rr, 0);
        chk({tag, "_jx"}, a_jx, 0);
        chk({tag, "_jy"}, a_jy, 0);
        chk({tag, "_we"}, a_we, 0);
        chk({tag, "_addr"}, a_addr, 0);
        chk({tag, "_data"}, a_data, 0);
    endtask

    task automatic model_reset();
        pend.delete();
        jlast = N - 1;
        rlast = N - 1;
        exp_wr = 1'b0;
        exp_addr = 0;
        exp_data = '0;
        started = 1'b0;
        done_seen = 1'b0;
    endtask

    typedef struct {
        int          core;
        int          x;
        int          y;
        logic [23:0] rgb;
        int          addr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 0,   0,   24'h123456, 0};
        tbl[1] = '{1, 319, 179, 24'hABCDEF, 57599};
        tbl[2] = '{0, 5,   1,   24'h000001, 325};
        tbl[3] = '{1, 100, 50,  24'hFFFFFF, 16100};
        tbl[4] = '{0, 319, 0,   24'h0F0F0F, 319};
        tbl[5] = '{1, 0,   179, 24'h808080, 57280};

        a_start = 0; a_jr = '0; a_rv = '0;
        a_rx = '0; a_ry = '0; a_rgb = '0;
        b_start = 0; b_jr = '0; b_rv = '0;
        b_rx = '0; b_ry = '0; b_rgb = '0;
        t = 0; mode = M_BOTH;
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_a_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // default-size instance: address arithmetic on result injection
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        #1;
        chk("b_busy", b_busy, 1);
        chk("b_jv_none_ready", b_jv, 0);
        chk("b_jx_held", b_jx, 0);
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            b_rv = '0;
            b_rv[tbl[v].core] = 1'b1;
            b_rx[tbl[v].core] = 9'(tbl[v].x);
            b_ry[tbl[v].core] = 8'(tbl[v].y);
            b_rgb[tbl[v].core] = tbl[v].rgb;
            #1;
            chk("b_res_ready", b_rr, b_rv);
            @(negedge clk);
            b_rv = '0;
            #1;
            chk("b_we", b_we, 1);
            chk("b_addr", b_addr, tbl[v].addr);
            chk("b_data", b_data, tbl[v].rgb);
        end
        @(negedge clk);
        #1;
        chk("b_we_low", b_we, 0);
        chk("b_addr_hold", b_addr, tbl[5].addr);

        run_frame(M_ONE, -1);
        run_frame(M_BOTH, -1);
        run_frame(M_HOLD, -1);
        run_frame(M_STALL, -1);
        for (int r = 0; r < 3; r++) run_frame(M_RAND, -1);

        // reset in DRAIN with three results still owed
        run_frame(M_HOLD, 5);
        chk("abort_pending", pend.size(), 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_a_zero("abort");
        a_rv = '0;
        a_jr = '0;
        a_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("abort_no_done", a_done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_frame(M_RAND, -1);
        run_frame(M_BOTH, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
